// File: rtl/fb_scanout.sv
`timescale 1ns/1ps
// fb_scanout
// Video scanout stage that follows the display processor. It generates
// 800x600@60 VGA timing from one pixel clock. It pixel-doubles a
// RESOLUTION_X x RESOLUTION_Y framebuffer of palette indices and resolves each
// index to RGB through a palette memory.
//
// Ports:
//   clk              pixel clock
//   reset            asynchronous, active-high reset
//   fb_rd_addr       framebuffer read address (synchronous read, 1 clk latency)
//   fb_rd_data       palette index returned by the framebuffer
//   palette_rd_addr  palette read address (the index just read from the framebuffer)
//   palette_rd_data  12-bit colour, R in the MSBs (synchronous read, 1 clk latency)
//   vga_r/g/b        registered pixel colour, forced to 0 outside the active area
//   vga_hs/vga_vs    registered sync outputs, equal to SYNC_POL while asserted
//   vblank_pulse     one-clock pulse on the first clock of the first blanking line
//
// A counter position presented at cycle t appears on the pins at cycle t+3.
module fb_scanout #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int H_ACTIVE       = 800,
    parameter int H_FP           = 40,
    parameter int H_SYNC         = 128,
    parameter int H_BP           = 88,
    parameter int V_ACTIVE       = 600,
    parameter int V_FP           = 1,
    parameter int V_SYNC         = 4,
    parameter int V_BP           = 23,
    parameter bit SYNC_POL       = 1'b1,
    localparam int ADDR_W        = $clog2(RESOLUTION_X * RESOLUTION_Y),
    localparam int IDX_W         = $clog2(PALETTE_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     fb_rd_addr,
    input  logic [IDX_W-1:0]      fb_rd_data,
    output logic [IDX_W-1:0]      palette_rd_addr,
    input  logic [COLOR_BITS-1:0] palette_rd_data,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vblank_pulse
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Base address of the last framebuffer row. It is used during vertical
    // blanking, because row_base has already stepped past the end of the buffer
    // by then.
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((RESOLUTION_Y - 1) * RESOLUTION_X);
    localparam logic [HW-1:0]     MAX_COL  = HW'(RESOLUTION_X - 1);

    // Saturate the doubled-pixel column so that horizontal blanking never
    // addresses past the end of the row.
    function automatic logic [HW-1:0] sat_col(input logic [HW-1:0] col);
        return (col > MAX_COL) ? MAX_COL : col;
    endfunction

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] row_base;
    logic              line_end;
    logic              frame_end;

    logic              vld_p0;
    logic              hs_p0;
    logic              vs_p0;
    logic [HW-1:0]     col_p0;
    logic [ADDR_W-1:0] row_p0;

    logic              vld_p1;
    logic              hs_p1;
    logic              vs_p1;
    logic              vld_p2;
    logic              hs_p2;
    logic              vs_p2;
    logic [11:0]       rgb_p3;

    assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Each framebuffer row is shown on two consecutive lines, so the row base
    // advances only at the end of odd lines. This replaces a v_cnt * RESOLUTION_X
    // multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
        end else if (frame_end) begin
            row_base <= '0;
        end else if (line_end && v_cnt[0] && (v_cnt < VW'(V_ACTIVE))) begin
            row_base <= row_base + ADDR_W'(RESOLUTION_X);
        end
    end

    // ---- Stage p0: counter position -> framebuffer address ----
    assign vld_p0     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_p0      = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    assign vs_p0      = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    assign row_p0     = (v_cnt < VW'(V_ACTIVE)) ? row_base : LAST_ROW;
    assign col_p0     = sat_col(h_cnt >> 1);
    assign fb_rd_addr = row_p0 + ADDR_W'(col_p0);

    // ---- Stage p1: framebuffer index -> palette address ----
    assign palette_rd_addr = fb_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
        end
    end

    // ---- Stage p2: palette colour valid ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    // ---- Stage p3: registered pins ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_p3       <= '0;
            vga_hs       <= ~SYNC_POL;
            vga_vs       <= ~SYNC_POL;
            vblank_pulse <= 1'b0;
        end else begin
            rgb_p3       <= vld_p2 ? 12'(palette_rd_data) : 12'h000;
            vga_hs       <= ~(hs_p2 ^ SYNC_POL);
            vga_vs       <= ~(vs_p2 ^ SYNC_POL);
            // vblank_pulse is not delayed through the pipeline. It marks the
            // first clock of line V_ACTIVE for the processor.
            vblank_pulse <= line_end && (v_cnt == VW'(V_ACTIVE - 1));
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_p3;

endmodule

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
// Testbench for fb_scanout. The horizontal timing is the default 800-pixel
// timing. The vertical size is reduced to 4 framebuffer rows: 8 active lines,
// front porch 1, sync 4, back porch 3, so 16 lines per frame. This keeps whole
// frames short enough to scan. Every sample is taken on the falling clock
// edge. n counts rising edges since the last reset release; after edge n the
// counters sit at position n and the pins show position n-3.
module tb_fb_scanout;

    localparam int RX    = 400;
    localparam int RY    = 4;
    localparam int HT    = 1056;
    localparam int VA    = 8;
    localparam int VT    = 16;
    localparam int FRAME = HT * VT;
    localparam int AW    = $clog2(RX * RY);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] fb_rd_addr;
    logic [7:0]    fb_rd_data = 8'h00;
    logic [7:0]    palette_rd_addr;
    logic [11:0]   palette_rd_data = 12'h000;
    logic [3:0]    vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vblank_pulse;
    logic          pal_force = 1'b0;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int vs_rise1 = -1;

    fb_scanout #(
        .RESOLUTION_Y(RY), .V_ACTIVE(VA), .V_FP(1), .V_SYNC(4), .V_BP(3)
    ) dut (
        .clk(clk), .reset(reset),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .palette_rd_addr(palette_rd_addr), .palette_rd_data(palette_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank_pulse(vblank_pulse)
    );

    always #12.5 clk = ~clk;

    // Memory models: fb(addr) = addr[7:0], palette(i) = {i, i[3:0]} or 0xFFF when forced
    always @(posedge clk) begin
        fb_rd_data      <= fb_rd_addr[7:0];
        palette_rd_data <= pal_force ? 12'hFFF : {palette_rd_addr, palette_rd_addr[3:0]};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic logic [11:0] exp_rgb(input int nn, input logic force_on);
        int k, h, v, a;
        logic [7:0] idx;
        if (nn < 3) return 12'h000;
        k = nn - 3; h = k % HT; v = (k / HT) % VT;
        if (h >= 800 || v >= VA) return 12'h000;
        if (force_on) return 12'hFFF;
        a = (v / 2) * RX + h / 2;
        idx = a[7:0];
        return {idx, idx[3:0]};
    endfunction

    function automatic logic exp_hs(input int nn);
        int h;
        if (nn < 3) return 1'b0;
        h = (nn - 3) % HT;
        return (h >= 840) && (h <= 967);
    endfunction

    function automatic logic exp_vs(input int nn);
        int v;
        if (nn < 3) return 1'b0;
        v = ((nn - 3) / HT) % VT;
        return (v >= 9) && (v <= 12);
    endfunction

    function automatic logic exp_vb(input int nn);
        return (nn > 0) && (nn % FRAME == VA * HT);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #15;
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b}); end
        checks++; if (vga_hs !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b want 0", vga_hs); end
        checks++; if (vga_vs !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b want 0", vga_vs); end
        checks++; if (vblank_pulse !== 1'b0) begin errors++; $display("FAIL reset_vblank: got %b want 0", vblank_pulse); end
        checks++; if (fb_rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", fb_rd_addr); end
        #7 reset = 1'b0;
        @(negedge clk);  // n = 0
        checks++; if (fb_rd_addr !== AW'(0)) begin errors++; $display("FAIL first_addr: got %0d want 0", fb_rd_addr); end
        @(negedge clk);  // n = 1
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b0) begin errors++; $display("FAIL pipe_empty: rgb %h hs %b want 000/0", {vga_r, vga_g, vga_b}, vga_hs); end
        @(negedge clk);  // n = 2
        checks++; if (fb_rd_addr !== AW'(1)) begin errors++; $display("FAIL addr_h2: got %0d want 1", fb_rd_addr); end
        @(negedge clk);  // n = 3: pixel (0,0)
        checks++; if ($isunknown({vga_r, vga_g, vga_b}) || {vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL pix00: got %h want 000", {vga_r, vga_g, vga_b}); end
        @(negedge clk);
        @(negedge clk);  // n = 5: fb addr 1
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h011) begin errors++; $display("FAIL pix_addr1: got %h want 011", {vga_r, vga_g, vga_b}); end
        @(negedge clk);
        @(negedge clk);  // n = 7: fb addr 2
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h022) begin errors++; $display("FAIL pix_addr2: got %h want 022", {vga_r, vga_g, vga_b}); end
    endtask

    // Scan the first frame and the first line of the second one.
    task automatic test_frame();
        int h, v;
        int bad_addr = 0, bad_rgb = 0, bad_sync = 0, bad_vb = 0;
        int hs_first = -1, hs_len0 = 0, vs_len = 0, vb_cnt = 0, vb_first = -1;
        int a_l1 = -1, a_l2 = -1, a_last = -1, a_wrap = -1;
        for (int i = 0; i < FRAME + 2 * HT && n <= FRAME + HT + 10; i++) begin
            h = n % HT; v = (n / HT) % VT;
            if (h < 800 && v < VA) begin
                if (fb_rd_addr !== AW'((v / 2) * RX + h / 2)) bad_addr++;
            end else if ($isunknown(fb_rd_addr) || fb_rd_addr > AW'(RX * RY - 1)) bad_addr++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n, 1'b0)) bad_rgb++;
            if (vga_hs !== exp_hs(n) || vga_vs !== exp_vs(n)) bad_sync++;
            if (vblank_pulse !== exp_vb(n)) bad_vb++;
            if (vga_hs === 1'b1 && hs_first < 0) hs_first = n;
            if (n < 3 + HT && vga_hs === 1'b1) hs_len0++;
            if (n < FRAME + 3 && vga_vs === 1'b1) vs_len++;
            if (vga_vs === 1'b1 && vs_rise1 < 0) vs_rise1 = n;
            if (n < FRAME && vblank_pulse === 1'b1) begin vb_cnt++; if (vb_first < 0) vb_first = n; end
            if (n == HT) a_l1 = int'(fb_rd_addr);
            if (n == 2 * HT) a_l2 = int'(fb_rd_addr);
            if (n == 7 * HT + 799) a_last = int'(fb_rd_addr);
            if (n == FRAME) a_wrap = int'(fb_rd_addr);
            @(negedge clk);
        end
        checks++; if (n <= FRAME + HT + 10) begin errors++; $display("FAIL frame_timeout: n %0d want > %0d", n, FRAME + HT + 10); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL frame_addr: %0d bad cycles, want 0", bad_addr); end
        checks++; if (bad_rgb != 0) begin errors++; $display("FAIL frame_rgb: %0d bad cycles, want 0", bad_rgb); end
        checks++; if (bad_sync != 0) begin errors++; $display("FAIL frame_sync: %0d bad cycles, want 0", bad_sync); end
        checks++; if (bad_vb != 0) begin errors++; $display("FAIL frame_vblank: %0d bad cycles, want 0", bad_vb); end
        checks++; if (hs_first != 843) begin errors++; $display("FAIL hs_rise: got %0d want 843", hs_first); end
        checks++; if (hs_len0 != 128) begin errors++; $display("FAIL hs_width: got %0d want 128", hs_len0); end
        checks++; if (vs_len != 4224) begin errors++; $display("FAIL vs_width: got %0d want 4224", vs_len); end
        checks++; if (vs_rise1 != 9507) begin errors++; $display("FAIL vs_rise: got %0d want 9507", vs_rise1); end
        checks++; if (vb_cnt != 1 || vb_first != 8448) begin errors++; $display("FAIL vblank_once: count %0d at %0d want 1 at 8448", vb_cnt, vb_first); end
        checks++; if (a_l1 != 0) begin errors++; $display("FAIL addr_line1: got %0d want 0", a_l1); end
        checks++; if (a_l2 != 400) begin errors++; $display("FAIL addr_line2: got %0d want 400", a_l2); end
        checks++; if (a_last != 1599) begin errors++; $display("FAIL addr_last: got %0d want 1599", a_last); end
        checks++; if (a_wrap != 0) begin errors++; $display("FAIL addr_wrap: got %0d want 0", a_wrap); end
    endtask

    // The palette returns 0xFFF everywhere. The pins must still be 0 whenever
    // the delayed active flag is low.
    task automatic test_blanking();
        int bs = FRAME + 7 * HT + 700;
        int be = FRAME + 10 * HT + 50;
        int bad_rgb = 0, fff_cnt = 0, zero_cnt = 0, vb_cnt = 0, vs_rise2 = -1;
        pal_force = 1'b1;
        for (int i = 0; i < 2 * FRAME && n < bs; i++) @(negedge clk);
        checks++; if (n != bs) begin errors++; $display("FAIL blank_wait: n %0d want %0d", n, bs); end
        for (int i = 0; i < 4 * HT && n <= be; i++) begin
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n, 1'b1)) bad_rgb++;
            if ({vga_r, vga_g, vga_b} === 12'hFFF) fff_cnt++;
            if ({vga_r, vga_g, vga_b} === 12'h000) zero_cnt++;
            if (vblank_pulse === 1'b1) vb_cnt++;
            if (vga_vs === 1'b1 && vs_rise2 < 0) vs_rise2 = n;
            @(negedge clk);
        end
        pal_force = 1'b0;
        checks++; if (bad_rgb != 0) begin errors++; $display("FAIL blank_rgb: %0d bad cycles, want 0", bad_rgb); end
        checks++; if (fff_cnt != 103) begin errors++; $display("FAIL blank_active: got %0d want 103", fff_cnt); end
        checks++; if (zero_cnt != be - bs + 1 - 103) begin errors++; $display("FAIL blank_zero: got %0d want %0d", zero_cnt, be - bs + 1 - 103); end
        checks++; if (vb_cnt != 1) begin errors++; $display("FAIL blank_vblank: got %0d want 1", vb_cnt); end
        checks++; if (vs_rise2 - vs_rise1 != FRAME) begin errors++; $display("FAIL frame_len: got %0d want %0d", vs_rise2 - vs_rise1, FRAME); end
    endtask

    // Reset mid-line during line 5 of the third frame, while hsync is on the pins.
    task automatic test_mid_reset();
        int mr = 2 * FRAME + 5 * HT + 903;
        int h, v;
        int bad_addr = 0, bad_rgb = 0, bad_sync = 0, vb_cnt = 0;
        logic [11:0] pix5 = 12'hxxx;
        for (int i = 0; i < 2 * FRAME && n < mr; i++) @(negedge clk);
        checks++; if (n != mr) begin errors++; $display("FAIL mr_wait: n %0d want %0d", n, mr); end
        checks++; if (vga_hs !== 1'b1) begin errors++; $display("FAIL mr_pre_hs: got %b want 1", vga_hs); end
        checks++; if (fb_rd_addr !== AW'(1199)) begin errors++; $display("FAIL mr_pre_addr: got %0d want 1199", fb_rd_addr); end
        #3 reset = 1'b1;
        #1;
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b0 || vga_vs !== 1'b0) begin errors++; $display("FAIL mr_pins: rgb %h hs %b vs %b want 000/0/0", {vga_r, vga_g, vga_b}, vga_hs, vga_vs); end
        checks++; if (fb_rd_addr !== AW'(0) || vblank_pulse !== 1'b0) begin errors++; $display("FAIL mr_addr: addr %0d vb %b want 0/0", fb_rd_addr, vblank_pulse); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2 * HT && n <= FRAME + HT + 5; i++) begin
            h = n % HT; v = (n / HT) % VT;
            if (h < 800 && v < VA) begin
                if (fb_rd_addr !== AW'((v / 2) * RX + h / 2)) bad_addr++;
            end else if ($isunknown(fb_rd_addr) || fb_rd_addr > AW'(RX * RY - 1)) bad_addr++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb(n, 1'b0)) bad_rgb++;
            if (vga_hs !== exp_hs(n) || vga_vs !== exp_vs(n)) bad_sync++;
            if (n < FRAME && vblank_pulse === 1'b1) vb_cnt++;
            if (n == 5) pix5 = {vga_r, vga_g, vga_b};
            @(negedge clk);
        end
        checks++; if (n <= FRAME + HT + 5) begin errors++; $display("FAIL mr_timeout: n %0d want > %0d", n, FRAME + HT + 5); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL mr_addr_walk: %0d bad cycles, want 0", bad_addr); end
        checks++; if (bad_rgb != 0) begin errors++; $display("FAIL mr_rgb: %0d bad cycles, want 0", bad_rgb); end
        checks++; if (bad_sync != 0) begin errors++; $display("FAIL mr_sync: %0d bad cycles, want 0", bad_sync); end
        checks++; if (pix5 !== 12'h011) begin errors++; $display("FAIL mr_pix5: got %h want 011", pix5); end
        checks++; if (vb_cnt != 1) begin errors++; $display("FAIL mr_vblank: got %0d want 1", vb_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_blanking();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Video scanout stage directly downstream of the display processor.
- Generates 800x600@60 VGA timing from a single pixel clock and pixel-doubles the 400x300 framebuffer.
- Reads 8-bit palette indices from the framebuffer read port, then resolves each index to 12-bit RGB through the palette read port.
- Drives registered RGB/HSYNC/VSYNC to the VGA pins and pulses a vblank event for the processor's I/O registers.

Parameters:
- RESOLUTION_X, 400, framebuffer width in pixels.
- RESOLUTION_Y, 300, framebuffer height in pixels.
- PALETTE_LENGTH, 256, number of palette entries; fb data width = $clog2(PALETTE_LENGTH).
- COLOR_BITS, 12, palette entry width (4R/4G/4B, R in MSBs).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 800/40/128/88, horizontal timing in clocks (H_TOTAL = 1056).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 600/1/4/23, vertical timing in lines (V_TOTAL = 628).
- SYNC_POL, 1, active level of hsync/vsync.

Ports:
- clk  in  1  pixel clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- fb_rd_addr  out  $clog2(RESOLUTION_X*RESOLUTION_Y)  framebuffer read address (17 bits at default).
- fb_rd_data  in  $clog2(PALETTE_LENGTH)  palette index; synchronous read, valid 1 clk after address.
- palette_rd_addr  out  $clog2(PALETTE_LENGTH)  palette read address.
- palette_rd_data  in  COLOR_BITS  color; synchronous read, valid 1 clk after address.
- vga_r, vga_g, vga_b  out  4 each  pixel color.
- vga_hs, vga_vs  out  1 each  sync outputs.
- vblank_pulse  out  1  one-clock pulse at start of vertical blanking.

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1.
  - h_cnt wraps to 0 after 1055 and increments v_cnt.
  - v_cnt wraps to 0 after 627 (on the same clock h_cnt wraps).
  - Both counters are 0 during reset and count from the first clk edge after reset deasserts.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Address generation: no multiplier.
  - Registered row_base adds RESOLUTION_X at each line end where v_cnt is odd and v_cnt < V_ACTIVE.
  - row_base clears to 0 at frame wrap.
  - fb_rd_addr = row_base + (h_cnt >> 1), combinational from registers.
  - Outside the active region fb_rd_addr holds row_base + min(h_cnt>>1, RESOLUTION_X-1); don't-care for data, but it must never exceed RESOLUTION_X*RESOLUTION_Y-1.
- palette_rd_addr = fb_rd_data, combinational.
- Pipeline (counter value at cycle t appears on the pins at t+3):
  - t+1: fb_rd_data valid.
  - t+2: palette_rd_data valid.
  - t+3: RGB/sync registered to the pins.
- Active, hsync and vsync flags travel through a matching 3-stage shift register so syncs and pixels stay aligned.
- Raw hsync = (h_cnt in 840..967). Raw vsync = (v_cnt in 601..604).
- Outputs: vga_hs/vga_vs = raw sync (delayed 3) XNOR SYNC_POL, i.e. equal to SYNC_POL when asserted.
- RGB: when the delayed active flag = 0, RGB = 0 (mandatory blanking). Otherwise {vga_r, vga_g, vga_b} = palette_rd_data.
- vblank_pulse: 1 for exactly one clk, registered, asserted on the clock after h_cnt = 1055 and v_cnt = 599 (first clock of line 600).
- Reset values: vga_r/g/b = 0; vga_hs = vga_vs = !SYNC_POL; vblank_pulse = 0; fb_rd_addr = 0; all delay stages cleared (inactive).
- Reset mid-frame: everything returns to reset values immediately (asynchronous). The scan restarts at (0,0), and the first active pixel reaches the pins 3 clocks after the first post-reset edge.
- Stalls: none. Memories are read every clock.

Test Plan:
- Reset held 22 ns, then released:
  - during reset, RGB = 0, hs = vs = 0 (SYNC_POL = 1), fb_rd_addr = 0;
  - h_cnt = 0 on the first edge;
  - pins show pixel (0,0) on the 3rd clk.
- Address walk on line 0:
  - fb_rd_addr = 0,0,1,1,…,399,399 over h_cnt 0..799;
  - line 1 repeats 0..399;
  - line 2 starts at 400;
  - line 599 ends at 119999;
  - new frame restarts at 0.
- Color path: fb model returns addr[7:0], palette model returns {index, index[3:0]}.
  - Pin color at output cycle 3 equals palette(fb(0)) = 0x000.
  - At output cycle 5 (fb addr 1) it equals 0x011.
  - No X on RGB.
- Sync timing:
  - vga_hs high for exactly 128 clks, rising 843 clks after line start (840+3);
  - vga_vs high for lines 601..604, 4 lines = 4224 clks;
  - frame length 663168 clks.
- Blanking: RGB = 0 on every clock where the delayed active flag = 0, including h_cnt 800..1055 and lines 600..627, even if the palette model returns 0xFFF.
- Mid-frame reset at line 123: outputs drop to reset values within the same timestep; the scan resumes at fb_rd_addr = 0; vblank_pulse fires exactly once per subsequent frame.
